// File: rtl/fetch_seq_pkg.sv
// Shared CPU definitions for the fetch sequencer: state encoding, output bundle
// and the text-segment base address used when tracking the PC.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic imem_rd;
        logic instr_valid;
        logic halted;
        logic busy;
    } fetch_out_t;

    localparam logic [31:0] TEXT_BASE_ADDR = 32'h0040_0000;
    localparam int          LAT_W          = 4;

    // Counter preload: the FETCH cycle itself accounts for one cycle of latency.
    function automatic logic [LAT_W-1:0] lat_load_val(input int lat);
        return LAT_W'(lat - 1);
    endfunction

    // Output strobes that belong to a state, registered alongside the state.
    function automatic fetch_out_t state_outputs(input fetch_state_t s);
        fetch_out_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.imem_rd = 1'b1;
                o.busy    = 1'b1;
            end
            WAIT:  o.busy = 1'b1;
            EXEC: begin
                o.instr_valid = 1'b1;
                o.busy        = 1'b1;
            end
            HALT:  o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fetch_seq_lat_counter.sv
// Loadable 4-bit down-counter for the instruction-memory read latency.
// o_zero reports the value being written this cycle, so the FSM can leave on time.
module lat_counter
    import fetch_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [LAT_W-1:0] r_count;
    logic [LAT_W-1:0] w_count_nxt;

    // Next count: load wins, decrement saturates at zero.
    always_comb begin
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            w_count_nxt = r_count - 4'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_zero = (w_count_nxt == 4'd0);

endmodule

// File: rtl/fetch_seq.sv
// Multi-cycle fetch sequencer: issues imem reads, waits out the latency, presents
// the instruction to decode, commits via pc_en, and handles load-hold and halt.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int IMEM_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             stall_req,
    input  logic             halt_req,
    output logic             imem_rd,
    output logic             instr_valid,
    output logic             pc_en,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [LAT_W-1:0] LAT_LOAD = lat_load_val(IMEM_LATENCY);

    fetch_state_t     r_state;
    fetch_out_t       r_out;
    logic [CNT_W-1:0] r_retired;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

    assign w_cnt_load = (r_state == FETCH);
    assign w_cnt_dec  = (r_state == WAIT);

    lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Sequencer FSM; strobes are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= HOLD;
            r_out     <= state_outputs(HOLD);
            r_retired <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (!hold) begin
                        r_state <= FETCH;
                        r_out   <= state_outputs(FETCH);
                    end
                end
                FETCH: begin
                    if (w_cnt_zero) begin
                        r_state <= EXEC;
                        r_out   <= state_outputs(EXEC);
                    end else begin
                        r_state <= WAIT;
                        r_out   <= state_outputs(WAIT);
                    end
                end
                WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= EXEC;
                        r_out   <= state_outputs(EXEC);
                    end
                end
                EXEC: begin
                    // A stall freezes commit; halt/hold only matter on the commit cycle.
                    if (!stall_req) begin
                        r_retired <= r_retired + CNT_W'(1);
                        if (halt_req) begin
                            r_state <= HALT;
                            r_out   <= state_outputs(HALT);
                        end else if (hold) begin
                            r_state <= HOLD;
                            r_out   <= state_outputs(HOLD);
                        end else begin
                            r_state <= FETCH;
                            r_out   <= state_outputs(FETCH);
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                    r_out   <= state_outputs(HALT);
                end
                default: begin
                    r_state <= HOLD;
                    r_out   <= state_outputs(HOLD);
                end
            endcase
        end
    end

    assign imem_rd     = r_out.imem_rd;
    assign instr_valid = r_out.instr_valid;
    assign halted      = r_out.halted;
    assign busy        = r_out.busy;
    assign pc_en       = r_out.instr_valid & ~stall_req;
    assign retired     = r_retired;

endmodule
